// File: rtl/arbitro_memoria_instrucoes_pkg.sv
// Shared definitions for the instruction-memory arbiter and the processor decoder.
// Opcodes, the NOP word and the arbiter phase encoding live here.
package arbitro_memoria_instrucoes_pkg;

  localparam int unsigned LARG_INSTR  = 32;
  localparam int unsigned LARG_OPCODE = 6;
  localparam int unsigned LARG_ALVO   = 26;

  localparam logic [LARG_OPCODE-1:0] OP_JUMP = 6'b000101;
  localparam logic [LARG_OPCODE-1:0] OP_NOP  = 6'b001100;

  localparam logic [LARG_INSTR-1:0] NOP_WORD = {OP_NOP, 26'd0};

  typedef enum logic [1:0] {
    CARGA    = 2'd0,
    EXECUCAO = 2'd1,
    PARADO   = 2'd2
  } estado_t;

  // Halt idiom: an unconditional jump whose target is its own address.
  function automatic logic eh_salto_para_si(input logic [LARG_INSTR-1:0] instrucao,
                                            input logic [LARG_ALVO-1:0]  endereco);
    return (instrucao[31:26] == OP_JUMP) && (instrucao[25:0] == endereco);
  endfunction

endpackage

// File: rtl/arbitro_memoria_instrucoes_detector_parada.sv
// Flags the jump-to-self halt idiom on the word currently fetched at the PC.
// Out-of-range fetches never count as a halt because they read aliased memory.
module detector_parada
  import arbitro_memoria_instrucoes_pkg::*;
#(
  parameter int unsigned LARG_END = 32
) (
  input  logic [LARG_INSTR-1:0] instrucao,
  input  logic [LARG_END-1:0]   endereco,
  input  logic                  em_faixa,
  output logic                  parada_c
);

  assign parada_c = em_faixa && eh_salto_para_si(instrucao, LARG_ALVO'(endereco));

endmodule

// File: rtl/arbitro_memoria_instrucoes.sv
// Single-port instruction memory arbiter: the loader owns the port in CARGA,
// the CPU fetch path owns it in EXECUCAO, and PARADO waits for a reload.
module arbitro_memoria_instrucoes
  import arbitro_memoria_instrucoes_pkg::*;
#(
  parameter int unsigned PROF     = 64,
  parameter int unsigned LARG_END = 32,
  parameter int unsigned LARG_CNT = 32
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [LARG_END-1:0]     CpuEndereco,
  output logic [LARG_INSTR-1:0]   CpuInstrucao,
  output logic                    CpuEspera,
  input  logic [LARG_INSTR-1:0]   CargaDado,
  input  logic                    CargaValido,
  input  logic                    CargaUltimo,
  output logic                    CargaAceito,
  output logic [$clog2(PROF)-1:0] MemEndereco,
  output logic [LARG_INSTR-1:0]   MemDadoEscrita,
  output logic                    MemEscrita,
  input  logic [LARG_INSTR-1:0]   MemInstrucao,
  output logic                    Parado,
  output logic                    ErroEndereco,
  output logic [LARG_CNT-1:0]     ContadorCiclos
);

  localparam int unsigned LARG_MEM = $clog2(PROF);
  localparam logic [LARG_END-1:0] LIMITE_END = LARG_END'(PROF);
  localparam logic [LARG_MEM-1:0] ULTIMO_END = LARG_MEM'(PROF - 1);

  estado_t              estado;
  estado_t              proximo;
  logic [LARG_MEM-1:0]  ponteiro;
  logic                 em_faixa;
  logic                 parada_c;
  logic                 fim_carga;

  assign em_faixa  = (CpuEndereco < LIMITE_END);
  assign fim_carga = CargaAceito && (CargaUltimo || (ponteiro == ULTIMO_END));

  detector_parada #(
    .LARG_END (LARG_END)
  ) u_detector_parada (
    .instrucao (MemInstrucao),
    .endereco  (CpuEndereco),
    .em_faixa  (em_faixa),
    .parada_c  (parada_c)
  );

  // Phase register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      estado <= CARGA;
    end else begin
      estado <= proximo;
    end
  end

  // Phase transitions.
  always_comb begin
    proximo = estado;
    unique case (estado)
      CARGA: begin
        if (fim_carga) proximo = EXECUCAO;
      end
      EXECUCAO: begin
        if (parada_c) proximo = PARADO;
      end
      PARADO: begin
        if (CargaValido) proximo = CARGA;
      end
      default: proximo = CARGA;
    endcase
  end

  // Port steering and CPU-facing outputs; Reset blocks any write in its own cycle.
  always_comb begin
    CpuInstrucao   = NOP_WORD;
    CpuEspera      = 1'b1;
    CargaAceito    = 1'b0;
    MemEscrita     = 1'b0;
    MemEndereco    = ponteiro;
    MemDadoEscrita = CargaDado;
    unique case (estado)
      CARGA: begin
        CargaAceito = CargaValido && !Reset;
        MemEscrita  = CargaValido && !Reset;
      end
      EXECUCAO: begin
        CpuEspera   = 1'b0;
        MemEndereco = CpuEndereco[LARG_MEM-1:0];
        if (em_faixa) CpuInstrucao = MemInstrucao;
      end
      default: begin
      end
    endcase
  end

  assign Parado = (estado == PARADO);

  // Load pointer, executed-cycle counter and sticky address error.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ponteiro       <= '0;
      ContadorCiclos <= '0;
      ErroEndereco   <= 1'b0;
    end else begin
      if (estado == CARGA) begin
        if (CargaAceito) ponteiro <= fim_carga ? '0 : ponteiro + LARG_MEM'(1);
      end else begin
        ponteiro <= '0;
      end
      if (estado == EXECUCAO) begin
        if (ContadorCiclos != '1) ContadorCiclos <= ContadorCiclos + LARG_CNT'(1);
        if (!em_faixa) ErroEndereco <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_arbitro_memoria_instrucoes.sv
// Bench for the instruction-memory arbiter: directed vector table, corner-case
// sequences and random traffic compared against a phase-level reference model.
module tb_arbitro_memoria_instrucoes;
  import arbitro_memoria_instrucoes_pkg::*;

  localparam int PROF = 64;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [31:0] CpuEndereco;
  logic [31:0] CpuInstrucao;
  logic        CpuEspera;
  logic [31:0] CargaDado;
  logic        CargaValido;
  logic        CargaUltimo;
  logic        CargaAceito;
  logic [5:0]  MemEndereco;
  logic [31:0] MemDadoEscrita;
  logic        MemEscrita;
  logic [31:0] MemInstrucao;
  logic        Parado;
  logic        ErroEndereco;
  logic [31:0] ContadorCiclos;

  always #5 Clock = ~Clock;

  arbitro_memoria_instrucoes #(.PROF(64), .LARG_END(32), .LARG_CNT(32)) dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .CpuEndereco    (CpuEndereco),
    .CpuInstrucao   (CpuInstrucao),
    .CpuEspera      (CpuEspera),
    .CargaDado      (CargaDado),
    .CargaValido    (CargaValido),
    .CargaUltimo    (CargaUltimo),
    .CargaAceito    (CargaAceito),
    .MemEndereco    (MemEndereco),
    .MemDadoEscrita (MemDadoEscrita),
    .MemEscrita     (MemEscrita),
    .MemInstrucao   (MemInstrucao),
    .Parado         (Parado),
    .ErroEndereco   (ErroEndereco),
    .ContadorCiclos (ContadorCiclos)
  );

  // Instruction memory: synchronous write, combinational read.
  logic [31:0] mem [PROF];
  always @(posedge Clock) if (MemEscrita) mem[MemEndereco] <= MemDadoEscrita;
  assign MemInstrucao = mem[MemEndereco];

  // Reference model: phase 0 = loading, 1 = running, 2 = halted.
  int          fase;
  int          ptr;
  logic [31:0] cnt;
  bit          err;
  logic [31:0] ref_mem [PROF];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nome, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nome, got, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit v, input bit u, input logic [31:0] d,
                       input logic [31:0] pc);
    Reset       = r;
    CargaValido = v;
    CargaUltimo = u;
    CargaDado   = d;
    CpuEndereco = pc;
  endtask

  task automatic checa_modelo();
    logic [31:0] e_instr;
    bit          e_esp;
    bit          e_ac;
    e_instr = NOP_WORD;
    e_esp   = 1'b1;
    e_ac    = 1'b0;
    if (fase == 0) begin
      e_ac = CargaValido && !Reset;
    end else if (fase == 1) begin
      e_esp = 1'b0;
      if (CpuEndereco < PROF) e_instr = ref_mem[CpuEndereco];
    end
    chk("espera", 64'(CpuEspera), 64'(e_esp));
    chk("instrucao", 64'(CpuInstrucao), 64'(e_instr));
    chk("aceito", 64'(CargaAceito), 64'(e_ac));
    chk("escrita", 64'(MemEscrita), 64'(e_ac));
    if (e_ac) begin
      chk("end_escrita", 64'(MemEndereco), 64'(ptr));
      chk("dado_escrita", 64'(MemDadoEscrita), 64'(CargaDado));
    end
    if (fase == 1) chk("end_leitura", 64'(MemEndereco), 64'(CpuEndereco % PROF));
    chk("parado", 64'(Parado), 64'(fase == 2));
    chk("erro", 64'(ErroEndereco), 64'(err));
    chk("contador", 64'(ContadorCiclos), 64'(cnt));
  endtask

  task automatic atualiza();
    logic [31:0] w;
    if (Reset) begin
      fase = 0; ptr = 0; cnt = '0; err = 1'b0;
    end else if (fase == 0) begin
      if (CargaValido) begin
        ref_mem[ptr] = CargaDado;
        if (CargaUltimo || ptr == PROF - 1) begin
          fase = 1; ptr = 0;
        end else begin
          ptr++;
        end
      end
    end else if (fase == 1) begin
      if (cnt != 32'hFFFF_FFFF) cnt++;
      if (CpuEndereco >= PROF) begin
        err = 1'b1;
      end else begin
        w = ref_mem[CpuEndereco];
        if (w[31:26] == 6'b000101 && w[25:0] == CpuEndereco[25:0]) fase = 2;
      end
    end else begin
      if (CargaValido) begin
        fase = 0; ptr = 0;
      end
    end
  endtask

  task automatic meio(input bit r, input bit v, input bit u, input logic [31:0] d,
                      input logic [31:0] pc);
    drive(r, v, u, d, pc);
    @(negedge Clock);
    checa_modelo();
  endtask

  task automatic borda();
    @(posedge Clock);
    atualiza();
    #1;
  endtask

  task automatic passo(input bit r, input bit v, input bit u, input logic [31:0] d,
                       input logic [31:0] pc);
    meio(r, v, u, d, pc);
    borda();
  endtask

  typedef struct {
    bit          r, v, u;
    logic [31:0] d;
    logic [31:0] pc;
    bit          e_ac;
    logic [5:0]  e_end;
    bit          e_esp;
    logic [31:0] e_instr;
  } vetor_t;

  vetor_t      tab [7];
  logic [31:0] d;
  logic [31:0] pc;
  logic [31:0] dado_63;

  initial begin
    for (int i = 0; i < PROF; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    fase = 0; ptr = 0; cnt = '0; err = 1'b0;

    // Three-word load, then fetches; the first row holds Reset with a valid word.
    tab[0] = '{1'b1, 1'b1, 1'b0, 32'h0BAD_0000, 32'd0, 1'b0, 6'd0, 1'b1, NOP_WORD};
    tab[1] = '{1'b0, 1'b1, 1'b0, 32'h1111_0000, 32'd0, 1'b1, 6'd0, 1'b1, NOP_WORD};
    tab[2] = '{1'b0, 1'b1, 1'b0, 32'h2222_0001, 32'd0, 1'b1, 6'd1, 1'b1, NOP_WORD};
    tab[3] = '{1'b0, 1'b1, 1'b1, 32'h3333_0002, 32'd0, 1'b1, 6'd2, 1'b1, NOP_WORD};
    tab[4] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'd1, 1'b0, 6'd1, 1'b0, 32'h2222_0001};
    tab[5] = '{1'b0, 1'b1, 1'b0, 32'h4444_4444, 32'd2, 1'b0, 6'd2, 1'b0, 32'h3333_0002};
    tab[6] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'd0, 1'b0, 6'd0, 1'b0, 32'h1111_0000};

    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    borda();

    foreach (tab[i]) begin
      meio(tab[i].r, tab[i].v, tab[i].u, tab[i].d, tab[i].pc);
      chk("tab_aceito", 64'(CargaAceito), 64'(tab[i].e_ac));
      chk("tab_escrita", 64'(MemEscrita), 64'(tab[i].e_ac));
      if (tab[i].e_ac || !tab[i].e_esp) chk("tab_end", 64'(MemEndereco), 64'(tab[i].e_end));
      chk("tab_espera", 64'(CpuEspera), 64'(tab[i].e_esp));
      chk("tab_instr", 64'(CpuInstrucao), 64'(tab[i].e_instr));
      borda();
    end

    // Full-depth load without a last marker; address 52 holds a jump-to-self.
    passo(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    dado_63 = '0;
    for (int i = 0; i < PROF; i++) begin
      d = (i == 52) ? 32'h1400_0034 : {6'b000000, 26'($urandom)};
      if (i == 63) dado_63 = d;
      meio(1'b0, 1'b1, 1'b0, d, 32'h0);
      if (i == 63) chk("auto_ultimo_aceito", 64'(CargaAceito), 64'd1);
      borda();
    end
    meio(1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'd63);
    chk("palavra65_recusada", 64'(CargaAceito), 64'd0);
    chk("execucao_apos_64", 64'(CpuEspera), 64'd0);
    chk("mem63_carregada", 64'(CpuInstrucao), 64'(dado_63));
    borda();
    for (int i = 0; i < 20; i++) begin
      pc = 32'($urandom_range(0, 63));
      if (pc == 32'd52) pc = 32'd51;
      passo(1'b0, 1'b0, 1'b0, 32'h0, pc);
    end
    meio(1'b0, 1'b0, 1'b0, 32'h0, 32'd52);
    chk("halt_instr", 64'(CpuInstrucao), 64'h1400_0034);
    chk("halt_espera", 64'(CpuEspera), 64'd0);
    chk("halt_contador", 64'(ContadorCiclos), 64'd21);
    borda();
    meio(1'b0, 1'b0, 1'b0, 32'h0, 32'd52);
    chk("parado_set", 64'(Parado), 64'd1);
    chk("parado_espera", 64'(CpuEspera), 64'd1);
    chk("parado_nop", 64'(CpuInstrucao), 64'(NOP_WORD));
    chk("parado_contador", 64'(ContadorCiclos), 64'd22);
    borda();
    passo(1'b0, 1'b0, 1'b0, 32'h0, 32'd7);
    meio(1'b0, 1'b0, 1'b0, 32'h0, 32'd9);
    chk("contador_congelado", 64'(ContadorCiclos), 64'd22);
    borda();

    // Reload from PARADO: the first word must be re-presented.
    meio(1'b0, 1'b1, 1'b1, 32'h0ABC_1234, 32'h0);
    chk("reload_sem_aceite", 64'(CargaAceito), 64'd0);
    borda();
    meio(1'b0, 1'b1, 1'b1, 32'h0ABC_1234, 32'h0);
    chk("reload_aceito", 64'(CargaAceito), 64'd1);
    chk("reload_end0", 64'(MemEndereco), 64'd0);
    chk("reload_parado_limpo", 64'(Parado), 64'd0);
    borda();
    meio(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("reload_mem0", 64'(CpuInstrucao), 64'h0ABC_1234);
    borda();

    // Out-of-range fetch and sticky error.
    meio(1'b0, 1'b0, 1'b0, 32'h0, 32'd70);
    chk("fora_nop", 64'(CpuInstrucao), 64'(NOP_WORD));
    chk("fora_erro_antes", 64'(ErroEndereco), 64'd0);
    borda();
    meio(1'b0, 1'b0, 1'b0, 32'h0, 32'd1);
    chk("erro_set", 64'(ErroEndereco), 64'd1);
    borda();
    meio(1'b0, 1'b0, 1'b0, 32'h0, 32'd64);
    chk("limite64_nop", 64'(CpuInstrucao), 64'(NOP_WORD));
    borda();
    passo(1'b0, 1'b0, 1'b0, 32'h0, 32'd63);
    meio(1'b0, 1'b0, 1'b0, 32'h0, 32'd2);
    chk("erro_pegajoso", 64'(ErroEndereco), 64'd1);
    borda();

    // Reset during the second load word.
    passo(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    passo(1'b0, 1'b1, 1'b0, 32'h0000_0AAA, 32'h0);
    meio(1'b1, 1'b1, 1'b0, 32'h0000_0BBB, 32'h0);
    chk("reset_sem_aceite", 64'(CargaAceito), 64'd0);
    chk("reset_sem_escrita", 64'(MemEscrita), 64'd0);
    borda();
    meio(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("pos_reset_espera", 64'(CpuEspera), 64'd1);
    chk("pos_reset_parado", 64'(Parado), 64'd0);
    chk("pos_reset_erro", 64'(ErroEndereco), 64'd0);
    chk("pos_reset_contador", 64'(ContadorCiclos), 64'd0);
    chk("pos_reset_nop", 64'(CpuInstrucao), 64'(NOP_WORD));
    borda();
    meio(1'b0, 1'b1, 1'b1, 32'h0000_0CCC, 32'h0);
    chk("reinicio_end0", 64'(MemEndereco), 64'd0);
    chk("reinicio_aceito", 64'(CargaAceito), 64'd1);
    borda();
    passo(1'b0, 1'b0, 1'b0, 32'h0, 32'd1);
    meio(1'b0, 1'b0, 1'b0, 32'h0, 32'd0);
    chk("reinicio_mem0", 64'(CpuInstrucao), 64'h0000_0CCC);
    borda();

    // Random traffic, with halt words planted at their own load address.
    for (int i = 0; i < 600; i++) begin
      bit r, v, u;
      r = ($urandom_range(0, 59) == 0);
      v = ($urandom_range(0, 2) != 0);
      u = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) d = {6'b000101, 26'(ptr)};
      else d = $urandom;
      if ($urandom_range(0, 7) == 0) pc = 32'($urandom_range(0, 90));
      else pc = 32'($urandom_range(0, 63));
      passo(r, v, u, d, pc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arbitro_memoria_instrucoes.md
Name: arbitro_memoria_instrucoes

Overview:
Owns the single port of the instruction memory and shares it between a program loader (boot/reload writes) and the processor fetch path (PC reads). Sequences the memory through load, execute and halted phases, and stalls the CPU while the loader owns the memory. Detects the halt idiom (jump-to-self) to end execution, and raises a sticky error on out-of-range fetches.

Parameters:
PROF, 64, instruction memory depth in 32-bit words
LARG_END, 32, width of CPU fetch address (PC)
LARG_CNT, 32, width of executed-cycle counter

Ports:
Clock  in  1  system clock, all state on posedge
Reset  in  1  synchronous, active-high reset
CpuEndereco  in  LARG_END  CPU fetch address (PC)
CpuInstrucao  out  32  instruction returned to CPU
CpuEspera  out  1  stall: CPU must hold PC and not commit
CargaDado  in  32  loader instruction word
CargaValido  in  1  loader word valid
CargaUltimo  in  1  marks final word of program (qualified by CargaValido)
CargaAceito  out  1  word accepted this cycle
MemEndereco  out  $clog2(PROF)  memory address
MemDadoEscrita  out  32  memory write data
MemEscrita  out  1  memory write enable
MemInstrucao  in  32  memory read data (combinational read)
Parado  out  1  halt reached
ErroEndereco  out  1  sticky: fetch address >= PROF
ContadorCiclos  out  LARG_CNT  cycles spent in EXECUCAO, saturating

Behaviour:
- Single clock Clock; Reset synchronous, active-high; Reset dominates every other input in the same cycle.
- Reset values: state CARGA, load pointer 0, CpuEspera=1, CargaAceito=0, MemEscrita=0, Parado=0, ErroEndereco=0, ContadorCiclos=0, CpuInstrucao=NOP (32'h3000_0000).
- States: CARGA, EXECUCAO, PARADO.
- CARGA: MemEndereco=pointer; MemDadoEscrita=CargaDado; MemEscrita=CargaAceito=CargaValido (combinational). Each accepted word increments the pointer. Leave for EXECUCAO next cycle when the accepted word has CargaUltimo=1 or pointer==PROF-1. Both conditions in the same cycle cause one transition. On exit, pointer resets to 0. CpuEspera=1, CpuInstrucao=NOP.
- EXECUCAO: CpuEspera=0; MemEscrita=0; CargaAceito=0, and CargaValido is ignored (not queued). MemEndereco=CpuEndereco[low bits]. CpuInstrucao=MemInstrucao with zero latency (combinational through).
  - If CpuEndereco>=PROF: CpuInstrucao=NOP and ErroEndereco sets next edge (sticky until Reset).
  - ContadorCiclos increments every EXECUCAO cycle and saturates at all-ones.
- Halt detect in EXECUCAO: MemInstrucao[31:26]==6'b000101 and MemInstrucao[25:0]==CpuEndereco[25:0], with address in range. Next state is PARADO and Parado=1 from the next cycle. The halt instruction itself is presented to the CPU in the detect cycle.
- PARADO: CpuEspera=1, CpuInstrucao=NOP, counter frozen.
  - CargaValido=1 starts a reload: go to CARGA next cycle with pointer 0 and Parado cleared. That first word is not accepted in PARADO (CargaAceito=0) and must be re-presented.
- Loader handshake: data transfers only when CargaValido & CargaAceito on a rising edge. The loader holds data while not accepted.
- Reset mid-load: the partial program stays in memory, the pointer returns to 0, and the load restarts.

Decomposition:
- Shared package: opcode constants OP_JUMP=6'b000101 and OP_NOP=6'b001100, constant NOP_WORD=32'h3000_0000, and the state enum {CARGA, EXECUCAO, PARADO}. The processor decoder reuses the package.
- One natural sub-module: detector_parada (combinational opcode/target compare against fetch address). Everything else stays in one module.

Test Plan:
- Reset, then load 3 words (A,B,C; C with CargaUltimo) on consecutive cycles -> MemEscrita at addresses 0,1,2; CargaAceito high 3 cycles; CpuEspera falls on the 4th edge; state EXECUCAO.
- Load PROF words without CargaUltimo -> auto-transition after address 63 is written; a 65th CargaValido is not accepted.
- In EXECUCAO, memory word at 52 = 32'h1400_0034, PC=52 -> that word is returned in the same cycle; Parado=1 and CpuEspera=1 the next cycle; ContadorCiclos frozen.
- PC=70 (PROF=64) -> CpuInstrucao=32'h3000_0000; ErroEndereco=1 next cycle, still 1 after PC returns in range.
- In PARADO, assert CargaValido with word D -> no accept that cycle; CARGA next cycle; D accepted at address 0; Parado cleared.
- Assert Reset during the 2nd load word -> all outputs at reset values next cycle; the next accepted word is written to address 0.
